// File: rtl/oqpsk_tx_framer_pkg.sv
// Shared definitions for the OQPSK transmit framer: FSM encoding, default sync word
// and counter widths.
package oqpsk_tx_framer_pkg;

    localparam int LEN_W = 8;
    localparam int CNT_W = 8;
    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_SYNC = 2'd2,
        ST_PAY  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/oqpsk_tx_framer_fifo.sv
// Synchronous byte FIFO feeding the framer payload stage. Read data is the word at the
// head pointer, so a pop and its data are consumed on the same edge.
module tx_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK50M,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_wr;
    logic        do_rd;

    // The extra pointer bit separates full from empty; the low AW bits wrap modulo DEPTH.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge CLK50M) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge CLK50M or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/oqpsk_tx_framer.sv
// Frame builder and serializer for the OQPSK modulator: preamble, sync word, then
// FIFO payload bytes MSB first, one bit per enabled bit strobe.
module oqpsk_tx_framer
    import oqpsk_tx_framer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          PRE_BITS   = 32,
    parameter int          SYNC_BITS  = 32,
    parameter logic [31:0] SYNC_WORD  = DEFAULT_SYNC_WORD
) (
    input  logic                          CLK50M,
    input  logic                          RST,
    input  logic                          EN,
    input  logic                          bit_stb,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          start,
    input  logic [LEN_W-1:0]              frame_len,
    output logic                          bit_out,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [31:0]      SYNC_ALIGNED = SYNC_WORD << (32 - SYNC_BITS);
    localparam logic [CNT_W-1:0] PRE_LAST     = CNT_W'(PRE_BITS - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_BITS - 1);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [LEN_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [31:0]      sync_sr_reg, sync_sr_next;
    logic [7:0]       pay_sr_reg, pay_sr_next;
    logic             bit_out_reg, bit_out_next;
    logic             done_reg, done_next;
    logic             underrun_reg, underrun_next;

    logic             step;
    logic             fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic [7:0]       pay_byte;

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK50M  (CLK50M),
        .RST     (RST),
        .wr_en   (din_valid && din_ready),
        .wr_data (din),
        .rd_en   (fifo_rd),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign step      = EN && bit_stb;
    assign din_ready = !fifo_full;
    assign busy      = (state_reg != ST_IDLE);
    assign bit_out   = bit_out_reg;
    assign done      = done_reg;
    assign underrun  = underrun_reg;
    assign pay_byte  = fifo_empty ? 8'h00 : fifo_data;

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        sync_sr_next  = sync_sr_reg;
        pay_sr_next   = pay_sr_reg;
        bit_out_next  = bit_out_reg;
        done_next     = 1'b0;
        underrun_next = underrun_reg;
        fifo_rd       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (step) bit_out_next = 1'b0;
                // The cycle carrying done still reads as idle, so a start there is dropped explicitly.
                if (start && (frame_len != '0) && !done_reg) begin
                    state_next    = ST_PRE;
                    bit_cnt_next  = '0;
                    byte_cnt_next = frame_len;
                    sync_sr_next  = SYNC_ALIGNED;
                    underrun_next = 1'b0;
                end
            end
            ST_PRE: begin
                if (step) begin
                    bit_out_next = ~bit_cnt_reg[0];
                    if (bit_cnt_reg == PRE_LAST) begin
                        state_next   = ST_SYNC;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (step) begin
                    bit_out_next = sync_sr_reg[31];
                    sync_sr_next = {sync_sr_reg[30:0], 1'b0};
                    if (bit_cnt_reg == SYNC_LAST) begin
                        state_next   = ST_PAY;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (byte_cnt_reg == '0) begin
                    // Last bit already loaded on the previous strobe; close the frame now.
                    if (EN) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end else if (step) begin
                    if (bit_cnt_reg[2:0] == 3'd0) begin
                        bit_out_next = pay_byte[7];
                        pay_sr_next  = {pay_byte[6:0], 1'b0};
                        if (fifo_empty) underrun_next = 1'b1;
                        else            fifo_rd       = 1'b1;
                    end else begin
                        bit_out_next = pay_sr_reg[7];
                        pay_sr_next  = {pay_sr_reg[6:0], 1'b0};
                    end
                    if (bit_cnt_reg[2:0] == 3'd7) begin
                        bit_cnt_next  = '0;
                        byte_cnt_next = byte_cnt_reg - 1'b1;
                    end else begin
                        bit_cnt_next  = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50M or negedge RST) begin
        if (!RST) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            sync_sr_reg  <= '0;
            pay_sr_reg   <= '0;
            bit_out_reg  <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            sync_sr_reg  <= sync_sr_next;
            pay_sr_reg   <= pay_sr_next;
            bit_out_reg  <= bit_out_next;
            done_reg     <= done_next;
            underrun_reg <= underrun_next;
        end
    end

endmodule

// File: tb/tb_oqpsk_tx_framer.sv
// Self-checking bench for oqpsk_tx_framer: frames are predicted from a queue model of
// the FIFO and the framing rules, then compared bit by bit at every enabled strobe.
module tb_oqpsk_tx_framer;

    localparam int          PRE_N  = 32;
    localparam int          SYNC_N = 32;
    localparam logic [31:0] SW     = 32'h1ACFFC1D;

    logic       CLK50M = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b1;
    logic       bit_stb = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       start = 1'b0;
    logic [7:0] frame_len = '0;
    logic       bit_out;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [4:0] fifo_level;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq[$];
    logic       got_q[$];
    logic       exp_q[$];

    always #10 CLK50M = ~CLK50M;

    oqpsk_tx_framer dut (
        .CLK50M     (CLK50M),
        .RST        (RST),
        .EN         (EN),
        .bit_stb    (bit_stb),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .start      (start),
        .frame_len  (frame_len),
        .bit_out    (bit_out),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        chk("din_ready_before_write", din_ready, 1);
        din = b;
        din_valid = 1'b1;
        @(negedge CLK50M);
        din_valid = 1'b0;
        mq.push_back(b);
        chk("fifo_level_after_write", fifo_level, mq.size());
    endtask

    task automatic pulse_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            bit_stb = 1'b1;
            @(negedge CLK50M);
            bit_stb = 1'b0;
            @(negedge CLK50M);
        end
    endtask

    // Drives one frame from start to done, checks every issued bit against the model.
    task automatic run_frame(input int len, input int freeze_at, input int freeze_n, input bit wr_at_pay);
        int   cyc;
        int   strobes;
        int   frozen;
        int   lvl0;
        bit   saw_done;
        bit   mid_start;
        bit   exp_under;
        bit   wr_now;
        logic [7:0] b;

        lvl0 = mq.size();
        exp_q.delete();
        got_q.delete();
        exp_under = 1'b0;
        for (int i = 0; i < PRE_N; i++) exp_q.push_back((i % 2) == 0);
        for (int i = 0; i < SYNC_N; i++) exp_q.push_back(SW[31 - i]);
        for (int k = 0; k < len; k++) begin
            if (mq.size() > 0) b = mq.pop_front();
            else begin b = 8'h00; exp_under = 1'b1; end
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        end

        chk("busy_before_start", busy, 0);
        start = 1'b1;
        frame_len = 8'(len);
        @(negedge CLK50M);
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        cyc = 0; strobes = 0; frozen = 0;
        saw_done = 1'b0; mid_start = 1'b0;
        while (!saw_done && cyc < 20000) begin
            bit_stb = ((cyc % 4) == 3);
            EN = !(freeze_n > 0 && strobes == freeze_at && frozen < freeze_n);
            if (strobes == 10 && !mid_start) begin
                start = 1'b1;
                frame_len = 8'd200;
                mid_start = 1'b1;
            end else begin
                start = 1'b0;
            end
            wr_now = wr_at_pay && bit_stb && EN && (strobes == PRE_N + SYNC_N);
            din_valid = wr_now;
            din = 8'h5A;
            @(negedge CLK50M);
            din_valid = 1'b0;
            if (wr_now) begin
                chk("level_wr_and_pop", fifo_level, lvl0);
                mq.push_back(8'h5A);
            end
            if (bit_stb && EN) begin
                got_q.push_back(bit_out);
                strobes++;
            end else if (bit_stb && !EN) begin
                frozen++;
                chk("frozen_bit_out", bit_out, got_q[got_q.size() - 1]);
                chk("frozen_busy", busy, 1);
            end
            if (done) saw_done = 1'b1;
            cyc++;
        end
        EN = 1'b1;
        bit_stb = 1'b0;
        chk("done_seen", saw_done, 1);
        chk("strobes_to_done", strobes, PRE_N + SYNC_N + 8 * len);
        chk("busy_at_done", busy, 0);
        chk("underrun", underrun, exp_under);
        chk("bit_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("bit_%0d", i), got_q[i], exp_q[i]);
        end

        // A start in the done cycle must be dropped.
        start = 1'b1;
        frame_len = 8'd5;
        @(negedge CLK50M);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done_start", busy, 0);
        chk("underrun_kept", underrun, exp_under);
        pulse_strobes(1);
        chk("bit_out_idle_zero", bit_out, 0);
        chk("level_after_frame", fifo_level, mq.size());
        $display("frame len=%0d strobes=%0d frozen=%0d underrun=%0b level=%0d",
                 len, strobes, frozen, underrun, fifo_level);
    endtask

    initial begin
        int nb;
        int len;

        // Reset state
        repeat (3) @(negedge CLK50M);
        chk("rst_bit_out", bit_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_din_ready", din_ready, 1);
        chk("rst_level", fifo_level, 0);
        RST = 1'b1;
        @(negedge CLK50M);

        // A5 3C FF frame
        write_byte(8'hA5);
        write_byte(8'h3C);
        write_byte(8'hFF);
        run_frame(3, 0, 0, 1'b0);

        // Short FIFO: 81 then a zero byte with underrun
        write_byte(8'h81);
        run_frame(2, 0, 0, 1'b0);

        // Zero-length start is ignored
        start = 1'b1;
        frame_len = 8'd0;
        @(negedge CLK50M);
        start = 1'b0;
        chk("len0_busy", busy, 0);
        pulse_strobes(2);
        chk("len0_bit_out", bit_out, 0);
        chk("len0_underrun_kept", underrun, 1);

        // Full FIFO, then simultaneous write and pop at level 8
        for (int i = 0; i < 16; i++) write_byte(8'($urandom));
        chk("full_din_ready", din_ready, 0);
        chk("full_level", fifo_level, 16);
        run_frame(8, 0, 0, 1'b0);
        run_frame(1, 0, 0, 1'b1);
        run_frame(8, 0, 0, 1'b0);

        // EN low for 10 strobes during the sync word
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        run_frame(2, 40, 10, 1'b0);

        // Randomized frames, sometimes short of data
        for (int r = 0; r < 4; r++) begin
            nb = $urandom_range(0, 4);
            len = $urandom_range(2, 6);
            for (int i = 0; i < nb; i++) write_byte(8'($urandom));
            run_frame(len, (r == 2) ? 70 : 0, (r == 2) ? 3 : 0, 1'b0);
        end

        // Reset in the middle of the payload
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        start = 1'b1;
        frame_len = 8'd4;
        @(negedge CLK50M);
        start = 1'b0;
        pulse_strobes(PRE_N + SYNC_N + 6);
        chk("mid_pay_busy", busy, 1);
        @(posedge CLK50M);
        #3 RST = 1'b0;
        #1;
        chk("rst_mid_bit_out", bit_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_underrun", underrun, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_din_ready", din_ready, 1);
        mq.delete();
        @(negedge CLK50M);
        RST = 1'b1;
        @(negedge CLK50M);
        run_frame(1, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
